// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   - FSM state encoding (RUN / DMEM_WAIT / DIV_WAIT / TRAP_PEND)
//   - zero-register constant used by the load-use compare
//   - default address / register-address widths
//   - packed per-stage control bundle and the fixed patterns it takes
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam int unsigned ZERO_REG = 0;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_DMEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DIV_WAIT  = 2'd2;
  localparam logic [1:0] ST_TRAP_PEND = 2'd3;

  // Hold/bubble controls for one cycle, stall_if is the MSB.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic flush_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE    = 8'b0000_0000;
  localparam ctrl_t CTRL_LOADUSE = 8'b1100_0100;
  localparam ctrl_t CTRL_IMEM    = 8'b1000_1000;
  localparam ctrl_t CTRL_DMEM    = 8'b1111_0001;
  localparam ctrl_t CTRL_DIV     = 8'b1110_0010;
  localparam ctrl_t CTRL_JUMP    = 8'b0000_1100;
  localparam ctrl_t CTRL_TRAP    = 8'b0000_1110;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the hazard-status inputs and the stall/flush/redirect outputs of
// the pipeline sequencer.
//   master : pipeline side, drives hazard status, receives controls
//   slave  : pipe_ctrl, receives hazard status, drives controls
// Parameters: ADDR_W (PC width), REG_AW (register-file address width).
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] id_reg1_raddr_i;
  logic [REG_AW-1:0] id_reg2_raddr_i;
  logic              id_reg1_RE_i;
  logic              id_reg2_RE_i;
  logic [REG_AW-1:0] ex_reg_waddr_i;
  logic              ex_mem_re_i;
  logic              ex_jump_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              ex_div_start_i;
  logic              div_done_i;
  logic              dmem_req_i;
  logic              dmem_ready_i;
  logic              imem_ready_i;
  logic              trap_req_i;
  logic [ADDR_W-1:0] trap_addr_i;

  logic              ctrl_stall_if_o;
  logic              ctrl_stall_id_o;
  logic              ctrl_stall_ex_o;
  logic              ctrl_stall_mem_o;
  logic              ctrl_flush_id_o;
  logic              ctrl_flush_ex_o;
  logic              ctrl_flush_mem_o;
  logic              ctrl_flush_wb_o;
  logic              ctrl_redirect_o;
  logic [ADDR_W-1:0] ctrl_redirect_addr_o;
  logic              ctrl_busy_o;

  modport master (
    output id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_RE_i, id_reg2_RE_i,
           ex_reg_waddr_i, ex_mem_re_i, ex_jump_i, ex_jump_addr_i,
           ex_div_start_i, div_done_i, dmem_req_i, dmem_ready_i,
           imem_ready_i, trap_req_i, trap_addr_i,
    input  ctrl_stall_if_o, ctrl_stall_id_o, ctrl_stall_ex_o, ctrl_stall_mem_o,
           ctrl_flush_id_o, ctrl_flush_ex_o, ctrl_flush_mem_o, ctrl_flush_wb_o,
           ctrl_redirect_o, ctrl_redirect_addr_o, ctrl_busy_o
  );

  modport slave (
    input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_RE_i, id_reg2_RE_i,
           ex_reg_waddr_i, ex_mem_re_i, ex_jump_i, ex_jump_addr_i,
           ex_div_start_i, div_done_i, dmem_req_i, dmem_ready_i,
           imem_ready_i, trap_req_i, trap_addr_i,
    output ctrl_stall_if_o, ctrl_stall_id_o, ctrl_stall_ex_o, ctrl_stall_mem_o,
           ctrl_flush_id_o, ctrl_flush_ex_o, ctrl_flush_mem_o, ctrl_flush_wb_o,
           ctrl_redirect_o, ctrl_redirect_addr_o, ctrl_busy_o
  );

endinterface

// File: rtl/pipe_ctrl_loaduse.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_loaduse
// Pure combinational load-use hazard detect: a load in EX whose destination
// is read by the instruction in ID. Writes to the zero register never
// create a hazard since x0 always reads as zero.
// Ports:
//   ex_mem_re_i      EX instruction is a load
//   ex_reg_waddr_i   EX destination register
//   id_reg1/2_*_i    ID source registers and their read enables
//   hazard_o         one-bubble stall required
// ---------------------------------------------------------------------------
module pipe_ctrl_loaduse
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_mem_re_i,
  input  logic [REG_AW-1:0] ex_reg_waddr_i,
  input  logic [REG_AW-1:0] id_reg1_raddr_i,
  input  logic              id_reg1_RE_i,
  input  logic [REG_AW-1:0] id_reg2_raddr_i,
  input  logic              id_reg2_RE_i,
  output logic              hazard_o
);

  logic match1;
  logic match2;

  assign match1   = id_reg1_RE_i && (id_reg1_raddr_i == ex_reg_waddr_i);
  assign match2   = id_reg2_RE_i && (id_reg2_raddr_i == ex_reg_waddr_i);
  assign hazard_o = ex_mem_re_i && (ex_reg_waddr_i != REG_AW'(ZERO_REG)) &&
                    (match1 || match2);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush sequencer for the 5-stage core. Covers hazards that
// forwarding cannot: load-use, multi-cycle divide, data/instruction memory
// wait, EX jump redirect and CSR trap redirect.
// Ports:
//   clk     core clock
//   rst_n   synchronous active-low reset
//   bus     pipe_ctrl_if.slave: hazard status in, stall/flush/redirect out
//   ctrl_stall_cnt_o / ctrl_flush_cnt_o  (only with PIPE_CTRL_PERF_EN)
//           saturating counts of IF-stall cycles and redirect cycles
// Optional feature macro: PIPE_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] ctrl_stall_cnt_o,
  output logic [PERF_W-1:0] ctrl_flush_cnt_o
`endif
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              trapPend_q;
  logic              trapPend_d;
  logic [ADDR_W-1:0] trapAddr_q;
  logic [ADDR_W-1:0] trapAddr_d;

  ctrl_t             ctrl;
  logic              redirect;
  logic [ADDR_W-1:0] redirectAddr;
  logic              loadUse;

  pipe_ctrl_loaduse #(
    .REG_AW (REG_AW)
  ) u_loaduse (
    .ex_mem_re_i     (bus.ex_mem_re_i),
    .ex_reg_waddr_i  (bus.ex_reg_waddr_i),
    .id_reg1_raddr_i (bus.id_reg1_raddr_i),
    .id_reg1_RE_i    (bus.id_reg1_RE_i),
    .id_reg2_raddr_i (bus.id_reg2_raddr_i),
    .id_reg2_RE_i    (bus.id_reg2_RE_i),
    .hazard_o        (loadUse)
  );

  // Next state, trap latch and the per-cycle controls. Everything visible on
  // the outputs is decided here from the current state and live inputs.
  always_comb begin
    ctrl         = CTRL_IDLE;
    redirect     = 1'b0;
    redirectAddr = '0;
    state_d      = state_q;
    trapPend_d   = trapPend_q;
    trapAddr_d   = trapAddr_q;

    case (state_q)
      ST_RUN: begin
        if (bus.trap_req_i) begin
          ctrl         = CTRL_TRAP;
          redirect     = 1'b1;
          redirectAddr = bus.trap_addr_i;
        end else if (bus.dmem_req_i && !bus.dmem_ready_i) begin
          ctrl    = CTRL_DMEM;
          state_d = ST_DMEM_WAIT;
        end else if (bus.ex_jump_i) begin
          // The jump's own divide still has to complete, so we wait for it
          // while the wrong-path instructions behind it are squashed.
          ctrl         = CTRL_JUMP;
          redirect     = 1'b1;
          redirectAddr = bus.ex_jump_addr_i;
          if (bus.ex_div_start_i) begin
            state_d = ST_DIV_WAIT;
          end
        end else if (bus.ex_div_start_i) begin
          ctrl    = CTRL_DIV;
          state_d = ST_DIV_WAIT;
        end else if (loadUse) begin
          ctrl = CTRL_LOADUSE;
        end else if (!bus.imem_ready_i) begin
          ctrl = CTRL_IMEM;
        end
      end

      ST_DMEM_WAIT: begin
        // First trap request wins; it is replayed once the access retires.
        if (bus.trap_req_i && !trapPend_q) begin
          trapPend_d = 1'b1;
          trapAddr_d = bus.trap_addr_i;
        end
        if (bus.dmem_ready_i) begin
          state_d = trapPend_d ? ST_TRAP_PEND : ST_RUN;
        end else begin
          ctrl = CTRL_DMEM;
        end
      end

      ST_DIV_WAIT: begin
        // A trap aborts the divide; returning to RUN makes any late
        // div_done_i irrelevant because RUN never looks at it.
        if (bus.trap_req_i) begin
          ctrl         = CTRL_TRAP;
          redirect     = 1'b1;
          redirectAddr = bus.trap_addr_i;
          state_d      = ST_RUN;
        end else if (bus.div_done_i) begin
          state_d = ST_RUN;
        end else begin
          ctrl = CTRL_DIV;
        end
      end

      ST_TRAP_PEND: begin
        ctrl         = CTRL_TRAP;
        redirect     = 1'b1;
        redirectAddr = trapAddr_q;
        trapPend_d   = 1'b0;
        state_d      = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and trap latch; reset drops any pending trap without redirecting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      trapPend_q <= 1'b0;
      trapAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      trapPend_q <= trapPend_d;
      trapAddr_q <= trapAddr_d;
    end
  end

  assign bus.ctrl_stall_if_o      = ctrl.stall_if;
  assign bus.ctrl_stall_id_o      = ctrl.stall_id;
  assign bus.ctrl_stall_ex_o      = ctrl.stall_ex;
  assign bus.ctrl_stall_mem_o     = ctrl.stall_mem;
  assign bus.ctrl_flush_id_o      = ctrl.flush_id;
  assign bus.ctrl_flush_ex_o      = ctrl.flush_ex;
  assign bus.ctrl_flush_mem_o     = ctrl.flush_mem;
  assign bus.ctrl_flush_wb_o      = ctrl.flush_wb;
  assign bus.ctrl_redirect_o      = redirect;
  assign bus.ctrl_redirect_addr_o = redirectAddr;
  assign bus.ctrl_busy_o          = (state_q != ST_RUN);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stallCnt_q;
  logic [PERF_W-1:0] flushCnt_q;

  // Saturating event counters: stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (ctrl.stall_if && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + PERF_W'(1);
      end
      if (redirect && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + PERF_W'(1);
      end
    end
  end

  assign ctrl_stall_cnt_o = stallCnt_q;
  assign ctrl_flush_cnt_o = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl. Inputs change 1 ns after the
// rising edge and outputs are compared 1 ns later, well away from the edge.
// Expected control patterns are {stall_if,id,ex,mem,flush_id,ex,mem,wb}.
// Optional macro: PIPE_CTRL_PERF_EN (also checks the counters after reset).
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(32), .REG_AW(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
`endif

  pipe_ctrl #(
    .ADDR_W (32),
    .REG_AW (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .ctrl_stall_cnt_o (stallCnt),
    .ctrl_flush_cnt_o (flushCnt)
`endif
  );

  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1100_0100;
  localparam logic [7:0] E_IMEM = 8'b1000_1000;
  localparam logic [7:0] E_DMEM = 8'b1111_0001;
  localparam logic [7:0] E_DIV  = 8'b1110_0010;
  localparam logic [7:0] E_JMP  = 8'b0000_1100;
  localparam logic [7:0] E_TRAP = 8'b0000_1110;

  typedef struct {
    logic        exMemRe;
    logic [4:0]  exW;
    logic [4:0]  rs1;
    logic        re1;
    logic [4:0]  rs2;
    logic        re2;
    logic        jump;
    logic [31:0] jAddr;
    logic        divStart;
    logic        divDone;
    logic        dReq;
    logic        dRdy;
    logic        iRdy;
    logic        trap;
    logic [31:0] tAddr;
  } stim_t;

  int checks = 0;
  int errors = 0;
  stim_t s;

  function automatic stim_t idleStim();
    stim_t t;
    t.exMemRe = 1'b0; t.exW = 5'd0; t.rs1 = 5'd0; t.re1 = 1'b0;
    t.rs2 = 5'd0; t.re2 = 1'b0; t.jump = 1'b0; t.jAddr = 32'h0;
    t.divStart = 1'b0; t.divDone = 1'b0; t.dReq = 1'b0; t.dRdy = 1'b0;
    t.iRdy = 1'b1; t.trap = 1'b0; t.tAddr = 32'h0;
    return t;
  endfunction

  // Drive one directed vector and let the combinational outputs settle.
  task automatic applyStimulus(input stim_t t);
    bus.ex_mem_re_i     = t.exMemRe;
    bus.ex_reg_waddr_i  = t.exW;
    bus.id_reg1_raddr_i = t.rs1;
    bus.id_reg1_RE_i    = t.re1;
    bus.id_reg2_raddr_i = t.rs2;
    bus.id_reg2_RE_i    = t.re2;
    bus.ex_jump_i       = t.jump;
    bus.ex_jump_addr_i  = t.jAddr;
    bus.ex_div_start_i  = t.divStart;
    bus.div_done_i      = t.divDone;
    bus.dmem_req_i      = t.dReq;
    bus.dmem_ready_i    = t.dRdy;
    bus.imem_ready_i    = t.iRdy;
    bus.trap_req_i      = t.trap;
    bus.trap_addr_i     = t.tAddr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expCtrl,
                             input logic expRedir, input logic [31:0] expAddr,
                             input logic expBusy);
    logic [7:0] obsCtrl;
    obsCtrl = {bus.ctrl_stall_if_o, bus.ctrl_stall_id_o, bus.ctrl_stall_ex_o,
               bus.ctrl_stall_mem_o, bus.ctrl_flush_id_o, bus.ctrl_flush_ex_o,
               bus.ctrl_flush_mem_o, bus.ctrl_flush_wb_o};
    checks++;
    assert (obsCtrl === expCtrl) else begin
      errors++;
      $error("[TB] FAIL %s ctrl observed %b expected %b", tag, obsCtrl, expCtrl);
    end
    checks++;
    assert (bus.ctrl_redirect_o === expRedir) else begin
      errors++;
      $error("[TB] FAIL %s redirect observed %b expected %b", tag, bus.ctrl_redirect_o, expRedir);
    end
    if (expRedir) begin
      checks++;
      assert (bus.ctrl_redirect_addr_o === expAddr) else begin
        errors++;
        $error("[TB] FAIL %s redirect_addr observed %h expected %h", tag, bus.ctrl_redirect_addr_o, expAddr);
      end
    end
    checks++;
    assert (bus.ctrl_busy_o === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy observed %b expected %b", tag, bus.ctrl_busy_o, expBusy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(idleStim());
    step();
    step();
    rst_n = 1'b1;

    applyStimulus(idleStim());
    checkOutput("reset_idle", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Load-use on rs1 = x5: exactly one bubble.
    s = idleStim(); s.exMemRe = 1; s.exW = 5; s.rs1 = 5; s.re1 = 1;
    applyStimulus(s);
    checkOutput("lu_x5", E_LU, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(idleStim());
    checkOutput("lu_after", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.exMemRe = 1; s.exW = 0; s.rs1 = 0; s.re1 = 1;
    applyStimulus(s);
    checkOutput("lu_x0", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.exMemRe = 1; s.exW = 7; s.rs1 = 3; s.re1 = 1; s.rs2 = 7; s.re2 = 1;
    applyStimulus(s);
    checkOutput("lu_rs2", E_LU, 1'b0, 32'h0, 1'b0);
    step();
    s.re2 = 0;
    applyStimulus(s);
    checkOutput("lu_rs2_no_re", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.exMemRe = 0; s.exW = 7; s.rs1 = 7; s.re1 = 1;
    applyStimulus(s);
    checkOutput("lu_not_load", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Instruction memory not ready, and load-use taking priority over it.
    s = idleStim(); s.iRdy = 0;
    applyStimulus(s);
    checkOutput("imem_wait", E_IMEM, 1'b0, 32'h0, 1'b0);
    step();
    s.exMemRe = 1; s.exW = 9; s.rs1 = 9; s.re1 = 1;
    applyStimulus(s);
    checkOutput("lu_over_imem", E_LU, 1'b0, 32'h0, 1'b0);
    step();

    // Data memory wait, ready on the fourth cycle.
    s = idleStim(); s.dReq = 1;
    applyStimulus(s);
    checkOutput("dmem_c1", E_DMEM, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(s);
      checkOutput("dmem_wait", E_DMEM, 1'b0, 32'h0, 1'b1);
      step();
    end
    s.dRdy = 1;
    applyStimulus(s);
    checkOutput("dmem_ready", E_NONE, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("dmem_back_run", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Traps during DMEM_WAIT: first one wins and is replayed after ready.
    s = idleStim(); s.dReq = 1;
    applyStimulus(s);
    checkOutput("dtrap_enter", E_DMEM, 1'b0, 32'h0, 1'b0);
    step();
    s.trap = 1; s.tAddr = 32'h0000_0100;
    applyStimulus(s);
    checkOutput("dtrap_100", E_DMEM, 1'b0, 32'h0, 1'b1);
    step();
    s.tAddr = 32'h0000_0200;
    applyStimulus(s);
    checkOutput("dtrap_200", E_DMEM, 1'b0, 32'h0, 1'b1);
    step();
    s = idleStim(); s.dReq = 1; s.dRdy = 1;
    applyStimulus(s);
    checkOutput("dtrap_ready", E_NONE, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("trap_pend", E_TRAP, 1'b1, 32'h0000_0100, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("trap_pend_done", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Trap arriving in the same cycle as dmem ready.
    s = idleStim(); s.dReq = 1;
    applyStimulus(s);
    checkOutput("dtrap2_enter", E_DMEM, 1'b0, 32'h0, 1'b0);
    step();
    s.dRdy = 1; s.trap = 1; s.tAddr = 32'h0000_0444;
    applyStimulus(s);
    checkOutput("dtrap2_ready", E_NONE, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("trap_pend2", E_TRAP, 1'b1, 32'h0000_0444, 1'b1);
    step();

    // Jumps: plain, over load-use, and losing to a dmem stall.
    s = idleStim(); s.jump = 1; s.jAddr = 32'h8000_0040;
    applyStimulus(s);
    checkOutput("jump", E_JMP, 1'b1, 32'h8000_0040, 1'b0);
    step();
    s.jAddr = 32'h8000_0042; s.exMemRe = 1; s.exW = 5; s.rs1 = 5; s.re1 = 1;
    applyStimulus(s);
    checkOutput("jump_over_lu", E_JMP, 1'b1, 32'h8000_0042, 1'b0);
    step();
    applyStimulus(idleStim());
    checkOutput("jump_after", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.jump = 1; s.jAddr = 32'h8000_0080; s.dReq = 1;
    applyStimulus(s);
    checkOutput("dmem_over_jump", E_DMEM, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.dReq = 1; s.dRdy = 1;
    applyStimulus(s);
    checkOutput("dmem_over_jump_rdy", E_NONE, 1'b0, 32'h0, 1'b1);
    step();

    // Trap in RUN beats everything and stays in RUN.
    s = idleStim(); s.trap = 1; s.tAddr = 32'h1234_5677; s.dReq = 1; s.jump = 1;
    s.jAddr = 32'h0000_0010;
    applyStimulus(s);
    checkOutput("trap_run", E_TRAP, 1'b1, 32'h1234_5677, 1'b0);
    step();
    applyStimulus(idleStim());
    checkOutput("trap_run_after", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Divide: 33 stall cycles, then div_done releases.
    s = idleStim(); s.divStart = 1;
    applyStimulus(s);
    checkOutput("div_start", E_DIV, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(idleStim());
      checkOutput("div_wait", E_DIV, 1'b0, 32'h0, 1'b1);
      step();
    end
    s = idleStim(); s.divDone = 1;
    applyStimulus(s);
    checkOutput("div_done", E_NONE, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("div_back_run", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Divide aborted by a trap on cycle 10; the late div_done is ignored.
    s = idleStim(); s.divStart = 1;
    applyStimulus(s);
    checkOutput("div2_start", E_DIV, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(idleStim());
      checkOutput("div2_wait", E_DIV, 1'b0, 32'h0, 1'b1);
      step();
    end
    s = idleStim(); s.trap = 1; s.tAddr = 32'h0000_0300;
    applyStimulus(s);
    checkOutput("div2_trap", E_TRAP, 1'b1, 32'h0000_0300, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("div2_run", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.divDone = 1;
    applyStimulus(s);
    checkOutput("div2_late_done", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    // Jump together with a divide start: redirect now, then wait.
    s = idleStim(); s.jump = 1; s.jAddr = 32'h0000_0040; s.divStart = 1;
    applyStimulus(s);
    checkOutput("jdiv_start", E_JMP, 1'b1, 32'h0000_0040, 1'b0);
    step();
    applyStimulus(idleStim());
    checkOutput("jdiv_wait", E_DIV, 1'b0, 32'h0, 1'b1);
    step();
    s = idleStim(); s.divDone = 1;
    applyStimulus(s);
    checkOutput("jdiv_done", E_NONE, 1'b0, 32'h0, 1'b1);
    step();

    // Reset in the middle of DIV_WAIT.
    s = idleStim(); s.divStart = 1;
    applyStimulus(s);
    step();
    applyStimulus(idleStim());
    checkOutput("rst_div_wait", E_DIV, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(idleStim());
    checkOutput("rst_div_after", E_NONE, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    assert (stallCnt === 32'h0) else begin
      errors++;
      $error("[TB] FAIL rst_stall_cnt observed %0d expected 0", stallCnt);
    end
    checks++;
    assert (flushCnt === 32'h0) else begin
      errors++;
      $error("[TB] FAIL rst_flush_cnt observed %0d expected 0", flushCnt);
    end
`endif
    step();

    // Reset with a latched trap: the trap must be dropped for good.
    s = idleStim(); s.dReq = 1;
    applyStimulus(s);
    step();
    s.trap = 1; s.tAddr = 32'h0000_0500;
    applyStimulus(s);
    checkOutput("rst_dtrap_wait", E_DMEM, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(idleStim());
    step();
    rst_n = 1'b1;
    applyStimulus(idleStim());
    checkOutput("rst_dtrap_after", E_NONE, 1'b0, 32'h0, 1'b0);
    step();
    s = idleStim(); s.dReq = 1;
    applyStimulus(s);
    checkOutput("rst_dtrap_dmem", E_DMEM, 1'b0, 32'h0, 1'b0);
    step();
    s.dRdy = 1;
    applyStimulus(s);
    checkOutput("rst_dtrap_rdy", E_NONE, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(idleStim());
    checkOutput("rst_dtrap_no_pend", E_NONE, 1'b0, 32'h0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
